multiplier_controller: RTL and testbench

Sequencing FSM that sits directly upstream of the Booth multiplier datapath of the multi-cycle MIPS core. It accepts a multiply request over a valid/ready handshake and registers both operands. It drives the datapath strobes (`initialize`, `accum_load`, `comp`, `sh_en`) from the datapath's `status`/`done` feedback, then captures the 2W-bit product into HI/LO registers and presents it with an output valid/ready handshake. It also flags the unsupported most-negative multiplicand and guards against a hung datapath with a watchdog.

---
 rtl/multiplier_controller_if.sv | 25 ++
 rtl/multiplier_controller.sv | 135 +++++++++++++
 tb/tb_multiplier_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_controller_if.sv
// Request/response handshake bundle between the multiply requester and the
// Booth multiplier sequencing controller.
interface multiplier_controller_if #(
    parameter int unsigned DATA_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] multiplicand;
    logic [DATA_WIDTH-1:0] multiplier;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            err;

    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, hi, lo, out_valid, err
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, hi, lo, out_valid, err
    );
endinterface

// File: rtl/multiplier_controller.sv
// Sequencing FSM for the Booth multiplier datapath: accepts a request, steps the
// datapath via strobes, captures the product into HI/LO and hands it back.
module multiplier_controller #(
    parameter int unsigned DATA_WIDTH    = 5,
    parameter int unsigned COUNTER_WIDTH = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    multiplier_controller_if.slave    host,
    output logic [DATA_WIDTH-1:0]     Operand1,
    output logic [DATA_WIDTH-1:0]     Operand2,
    output logic                      initialize,
    output logic                      accum_load,
    output logic                      comp,
    output logic                      sh_en,
    input  logic [1:0]                status,
    input  logic                      done,
    input  logic [2*DATA_WIDTH-1:0]   result
);

    // COUNTER_WIDTH holds W, so two extra bits always cover 3W+2.
    localparam int unsigned           WdogWidth = COUNTER_WIDTH + 2;
    localparam logic [WdogWidth-1:0]  WdogLast  = WdogWidth'(3 * DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] MostNeg   = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StCheck,
        StAdd,
        StShift,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic                  comp_q, comp_d;
    logic [WdogWidth-1:0]  wdog_q;
    logic [DATA_WIDTH-1:0] hi_q, lo_q;
    logic [1:0]            err_q;
    logic                  working, accept, capture, timeout;

    assign working = (state_q == StCheck) || (state_q == StAdd) || (state_q == StShift);
    assign accept  = (state_q == StIdle) && host.in_valid;
    assign capture = (state_q == StCheck) && done;
    // A capture on the last allowed cycle still wins over the watchdog.
    assign timeout = working && !capture && (wdog_q == WdogLast);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            comp_q   <= 1'b0;
            wdog_q   <= '0;
            Operand1 <= '0;
            Operand2 <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            err_q    <= '0;
        end else begin
            state_q <= state_d;
            comp_q  <= comp_d;
            if (state_q == StInit) begin
                wdog_q <= '0;
            end else if (working) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (accept) begin
                Operand1 <= host.multiplicand;
                Operand2 <= host.multiplier;
                err_q    <= {1'b0, host.multiplicand == MostNeg};
            end
            if (timeout) begin
                hi_q     <= '0;
                lo_q     <= '0;
                err_q[1] <= 1'b1;
            end else if (capture) begin
                hi_q <= result[2*DATA_WIDTH-1:DATA_WIDTH];
                lo_q <= result[DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        comp_d  = comp_q;
        unique case (state_q)
            StIdle:  if (host.in_valid) state_d = StInit;
            StInit:  state_d = StCheck;
            StCheck: begin
                if (done) begin
                    state_d = StDone;
                end else if (status == 2'b01) begin
                    state_d = StAdd;
                    comp_d  = 1'b0;
                end else if (status == 2'b10) begin
                    state_d = StAdd;
                    comp_d  = 1'b1;
                end else begin
                    state_d = StShift;
                end
            end
            StAdd:   state_d = StShift;
            StShift: state_d = StCheck;
            StDone:  if (host.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (timeout) begin
            state_d = StDone;
        end
    end

    always_comb begin
        initialize     = 1'b0;
        accum_load     = 1'b0;
        comp           = 1'b0;
        sh_en          = 1'b0;
        host.in_ready  = 1'b0;
        host.out_valid = 1'b0;
        unique case (state_q)
            StIdle:  host.in_ready = 1'b1;
            StInit:  initialize = 1'b1;
            StAdd: begin
                accum_load = 1'b1;
                comp       = comp_q;
            end
            StShift: sh_en = 1'b1;
            StDone:  host.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign host.hi  = hi_q;
    assign host.lo  = lo_q;
    assign host.err = err_q;

endmodule

// File: tb/tb_multiplier_controller.sv
// Directed bench for multiplier_controller driving a behavioural Booth datapath.
module tb_multiplier_controller;
    localparam int W = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    multiplier_controller_if #(.DATA_WIDTH(W)) bus ();

    logic [W-1:0]   Operand1, Operand2;
    logic           initialize, accum_load, comp, sh_en, done;
    logic [1:0]     status;
    logic [2*W-1:0] result;

    multiplier_controller #(
        .DATA_WIDTH   (W),
        .COUNTER_WIDTH(3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .host      (bus),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .initialize(initialize),
        .accum_load(accum_load),
        .comp      (comp),
        .sh_en     (sh_en),
        .status    (status),
        .done      (done),
        .result    (result)
    );

    // Behavioural Booth datapath: A accumulator, Q multiplier, Q[-1], shift count.
    logic [W-1:0] dp_a = '0;
    logic [W-1:0] dp_q = '0;
    logic         dp_qm1 = 1'b0;
    logic [7:0]   dp_cnt = '0;
    logic         dp_done = 1'b0;
    logic         kill_done = 1'b0;

    always @(posedge CLK) begin
        if (initialize) begin
            dp_a    <= '0;
            dp_q    <= Operand2;
            dp_qm1  <= 1'b0;
            dp_cnt  <= '0;
            dp_done <= 1'b0;
        end else begin
            dp_done <= 1'b0;
            if (accum_load) dp_a <= comp ? dp_a - Operand1 : dp_a + Operand1;
            if (sh_en) begin
                {dp_a, dp_q, dp_qm1} <= {dp_a[W-1], dp_a, dp_q};
                dp_cnt  <= dp_cnt + 8'd1;
                dp_done <= (dp_cnt == 8'(W - 1));
            end
        end
    end

    assign status = {dp_q[0], dp_qm1};
    assign done   = dp_done && !kill_done;
    assign result = {dp_a, dp_q};

    int         tot_init = 0, tot_acc = 0, tot_sh = 0, tot_bad = 0;
    logic [7:0] comp_hist = '0;

    always @(negedge CLK) begin
        if (initialize) tot_init++;
        if (sh_en) tot_sh++;
        if (accum_load) begin
            tot_acc++;
            comp_hist = {comp_hist[6:0], comp};
        end
        if ((int'(initialize) + int'(accum_load) + int'(sh_en) > 1) ||
            ((initialize || accum_load || sh_en) && (bus.in_ready || bus.out_valid)))
            tot_bad++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge CLK);
        check("in_ready_before", 32'(bus.in_ready), 1);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.in_valid     = 1'b1;
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge CLK);
        #1;
        bus.out_ready = 1'b0;
        check("out_valid_drop", 32'(bus.out_valid), 0);
        check("in_ready_back", 32'(bus.in_ready), 1);
    endtask

    int lat, acc0, sh0, init0, bad0, n;

    initial begin
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_hilo", 32'({bus.hi, bus.lo}), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_strobes", 32'({initialize, accum_load, sh_en}), 0);
        RST = 1'b0;

        // 5 x 3: subtract then add
        acc0 = tot_acc;
        run_op(5'd5, 5'd3, lat);
        check("5x3_lat", 32'(lat), 14);
        check("5x3_hi", 32'(bus.hi), 32'h00);
        check("5x3_lo", 32'(bus.lo), 32'h0f);
        check("5x3_err", 32'(bus.err), 0);
        check("5x3_nacc", 32'(tot_acc - acc0), 2);
        check("5x3_comp_order", 32'(comp_hist[1:0]), 32'h2);
        init0 = tot_init;
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            #1;
            check("done_holdoff_ready", 32'(bus.in_ready), 0);
            check("done_holdoff_valid", 32'(bus.out_valid), 1);
        end
        bus.in_valid = 1'b0;
        check("done_no_init", 32'(tot_init - init0), 0);
        finish_op();

        // -3 x 4
        run_op(5'b11101, 5'b00100, lat);
        check("m3x4_lat", 32'(lat), 14);
        check("m3x4_hi", 32'(bus.hi), 32'h1f);
        check("m3x4_lo", 32'(bus.lo), 32'h14);
        check("m3x4_err", 32'(bus.err), 0);
        finish_op();

        // 7 x 0: shifts only
        acc0 = tot_acc; sh0 = tot_sh; init0 = tot_init;
        run_op(5'd7, 5'd0, lat);
        check("7x0_lat", 32'(lat), 12);
        check("7x0_hilo", 32'({bus.hi, bus.lo}), 0);
        check("7x0_nacc", 32'(tot_acc - acc0), 0);
        check("7x0_nsh", 32'(tot_sh - sh0), 5);
        check("7x0_ninit", 32'(tot_init - init0), 1);
        finish_op();

        // Watchdog: done never reaches the controller
        kill_done = 1'b1;
        run_op(5'd5, 5'd3, lat);
        check("wdog_lat", 32'(lat), 18);
        check("wdog_err", 32'(bus.err), 32'h2);
        check("wdog_hilo", 32'({bus.hi, bus.lo}), 0);
        sh0 = tot_sh; acc0 = tot_acc; bad0 = tot_bad;
        repeat (3) @(posedge CLK);
        #1;
        check("wdog_no_strobe", 32'((tot_sh - sh0) + (tot_acc - acc0) + (tot_bad - bad0)), 0);
        check("wdog_valid_held", 32'(bus.out_valid), 1);
        kill_done = 1'b0;
        finish_op();

        // -16 x 1: most-negative multiplicand flagged, run still completes
        run_op(5'b10000, 5'd1, lat);
        check("neg16_lat", 32'(lat), 14);
        check("neg16_valid", 32'(bus.out_valid), 1);
        check("neg16_err", 32'(bus.err), 32'h1);
        finish_op();

        // Reset in the middle of a 5 x 3 run
        @(negedge CLK);
        bus.multiplicand = 5'd5;
        bus.multiplier   = 5'd3;
        bus.in_valid     = 1'b1;
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!sh_en && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("rst_reached_shift", 32'(sh_en), 1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("midrst_strobes", 32'({initialize, accum_load, sh_en}), 0);
        check("midrst_in_ready", 32'(bus.in_ready), 1);
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_hilo_err", 32'({bus.hi, bus.lo, bus.err}), 0);
        check("midrst_operands", 32'({Operand1, Operand2}), 0);

        // 2 x 2 after reset, consumer stalls three cycles
        run_op(5'd2, 5'd2, lat);
        check("2x2_lat", 32'(lat), 14);
        check("2x2_hi", 32'(bus.hi), 0);
        check("2x2_lo", 32'(bus.lo), 32'h04);
        repeat (3) begin
            @(posedge CLK);
            #1;
            check("2x2_valid_held", 32'(bus.out_valid), 1);
            check("2x2_lo_held", 32'(bus.lo), 32'h04);
        end
        finish_op();
        check("2x2_lo_after", 32'(bus.lo), 32'h04);

        check("strobe_exclusive", 32'(tot_bad), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
